// File: rtl/params_pkg.sv
// Shared types and constants for the ACE snoop port: bus widths,
// AC snoop encodings, CR response bit positions and the port FSM states.
package params_pkg;

    localparam int unsigned SNOOP_ADD_BUS_WIDTH  = 32;
    localparam int unsigned SNOOP_DATA_BUS_WIDTH = 64;

    localparam int unsigned CR_DATA_XFER  = 0;
    localparam int unsigned CR_ERROR      = 1;
    localparam int unsigned CR_PASS_DIRTY = 2;
    localparam int unsigned CR_IS_SHARED  = 3;
    localparam int unsigned CR_WAS_UNIQUE = 4;

    typedef enum logic [3:0] {
        AC_READ_ONCE             = 4'b0000,
        AC_READ_SHARED           = 4'b0001,
        AC_READ_CLEAN            = 4'b0010,
        AC_READ_NOT_SHARED_DIRTY = 4'b0011,
        AC_READ_UNIQUE           = 4'b0111,
        AC_CLEAN_SHARED          = 4'b1000,
        AC_CLEAN_INVALID         = 4'b1001,
        AC_MAKE_INVALID          = 4'b1101,
        AC_DVM_COMPLETE          = 4'b1110,
        AC_DVM_MESSAGE           = 4'b1111
    } ace_ac_snoop_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_AC = 2'd1,
        WAIT    = 2'd2,
        RESP    = 2'd3
    } snoop_port_state_e;

endpackage

// File: rtl/ace_snoop_port.sv
// Interconnect-side snoop port for one ACE master: issues one snoop on AC,
// gathers CR and CD, forwards data beats and a summarised response.
module ace_snoop_port #(
    parameter int unsigned SNOOP_ADD_BUS_WIDTH  = params_pkg::SNOOP_ADD_BUS_WIDTH,
    parameter int unsigned SNOOP_DATA_BUS_WIDTH = params_pkg::SNOOP_DATA_BUS_WIDTH,
    parameter int unsigned CD_BEATS             = 4
) (
    input  logic                            aclk,
    input  logic                            arst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [SNOOP_ADD_BUS_WIDTH-1:0]  req_addr,
    input  params_pkg::ace_ac_snoop_e       req_snoop,
    input  logic [2:0]                      req_prot,
    output logic                            ac_valid,
    input  logic                            ac_ready,
    output logic [SNOOP_ADD_BUS_WIDTH-1:0]  ac_addr,
    output params_pkg::ace_ac_snoop_e       ac_snoop,
    output logic [2:0]                      ac_prot,
    input  logic                            cr_valid,
    output logic                            cr_ready,
    input  logic [4:0]                      cr_resp,
    input  logic                            cd_valid,
    output logic                            cd_ready,
    input  logic [SNOOP_DATA_BUS_WIDTH-1:0] cd_data,
    input  logic                            cd_last,
    output logic                            dat_valid,
    input  logic                            dat_ready,
    output logic [SNOOP_DATA_BUS_WIDTH-1:0] dat_data,
    output logic                            dat_last,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [4:0]                      rsp_resp,
    output logic                            rsp_err
);
    import params_pkg::*;

    localparam int unsigned      CNT_W      = $clog2(CD_BEATS) + 1;
    localparam logic [CNT_W-1:0] BEATS_FULL = CNT_W'(CD_BEATS);
    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(CD_BEATS - 1);

    snoop_port_state_e              state_q, state_d;
    logic [SNOOP_ADD_BUS_WIDTH-1:0] addr_q, addr_d;
    ace_ac_snoop_e                  snoop_q, snoop_d;
    logic [2:0]                     prot_q, prot_d;
    logic [4:0]                     cr_q, cr_d;
    logic                           cr_got_q, cr_got_d;
    logic                           err_q, err_d;
    logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;

    logic in_wait, cr_hs, cd_hs, cd_drop;

    assign in_wait   = (state_q == WAIT);
    assign req_ready = (state_q == IDLE);
    assign ac_valid  = (state_q == SEND_AC);
    assign rsp_valid = (state_q == RESP);
    assign cr_ready  = in_wait && !cr_got_q;
    assign cd_ready  = in_wait && dat_ready;
    assign cr_hs     = cr_valid && cr_ready;
    assign cd_hs     = cd_valid && cd_ready;

    // A beat is stray when it rides with or follows a no-data CR, or would overflow the line.
    assign cd_drop   = (cr_got_q && !cr_q[CR_DATA_XFER])
                     || (cr_hs && !cr_resp[CR_DATA_XFER])
                     || (beat_cnt_q == BEATS_FULL);

    assign dat_valid = in_wait && cd_valid && !cd_drop;
    assign dat_data  = cd_data;
    assign dat_last  = (beat_cnt_q == BEAT_LAST);
    assign ac_addr   = addr_q;
    assign ac_snoop  = snoop_q;
    assign ac_prot   = prot_q;
    assign rsp_resp  = cr_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        snoop_d    = snoop_q;
        prot_d     = prot_q;
        cr_d       = cr_q;
        cr_got_d   = cr_got_q;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    snoop_d    = req_snoop;
                    prot_d     = req_prot;
                    cr_d       = '0;
                    cr_got_d   = 1'b0;
                    err_d      = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = SEND_AC;
                end
            end
            SEND_AC: begin
                if (ac_ready) state_d = WAIT;
            end
            WAIT: begin
                if (cr_hs) begin
                    cr_got_d = 1'b1;
                    cr_d     = cr_resp;
                    if (cr_resp[CR_ERROR]) err_d = 1'b1;
                end
                if (cd_hs) begin
                    if (cd_drop) begin
                        err_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (cd_last != dat_last) err_d = 1'b1;
                    end
                end
                // Completion is judged on this cycle's captures so CR and the final beat may coincide.
                if (cr_got_d && (!cr_d[CR_DATA_XFER] || beat_cnt_d == BEATS_FULL))
                    state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            snoop_q    <= AC_READ_ONCE;
            prot_q     <= '0;
            cr_q       <= '0;
            cr_got_q   <= 1'b0;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            snoop_q    <= snoop_d;
            prot_q     <= prot_d;
            cr_q       <= cr_d;
            cr_got_q   <= cr_got_d;
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ace_snoop_port.sv
// Self-checking bench for ace_snoop_port: directed table, hand-written
// latency/reset sequences and randomized snoops against a transaction model.
module tb_ace_snoop_port;
    import params_pkg::*;

    localparam int unsigned BEATS = 4;
    localparam int unsigned AW    = SNOOP_ADD_BUS_WIDTH;
    localparam int unsigned DW    = SNOOP_DATA_BUS_WIDTH;

    logic          aclk = 1'b0;
    logic          arst;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    ace_ac_snoop_e req_snoop;
    logic [2:0]    req_prot;
    logic          ac_valid, ac_ready;
    logic [AW-1:0] ac_addr;
    ace_ac_snoop_e ac_snoop;
    logic [2:0]    ac_prot;
    logic          cr_valid, cr_ready;
    logic [4:0]    cr_resp;
    logic          cd_valid, cd_ready;
    logic [DW-1:0] cd_data;
    logic          cd_last;
    logic          dat_valid, dat_ready;
    logic [DW-1:0] dat_data;
    logic          dat_last;
    logic          rsp_valid, rsp_ready;
    logic [4:0]    rsp_resp;
    logic          rsp_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 aclk = ~aclk;

    ace_snoop_port #(
        .SNOOP_ADD_BUS_WIDTH (AW),
        .SNOOP_DATA_BUS_WIDTH(DW),
        .CD_BEATS            (BEATS)
    ) dut (
        .aclk(aclk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_snoop(req_snoop), .req_prot(req_prot),
        .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr),
        .ac_snoop(ac_snoop), .ac_prot(ac_prot),
        .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_resp(cr_resp),
        .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data), .cd_last(cd_last),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_last(dat_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_err(rsp_err)
    );

    typedef struct {
        ace_ac_snoop_e sn;
        logic [4:0]    cr;
        int unsigned   cr_after;
        int unsigned   last_idx;
        bit            stray;
        int unsigned   dr_mode;
        logic [4:0]    exp_resp;
        bit            exp_err;
        int unsigned   exp_beats;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_addr = '0; req_snoop = AC_READ_ONCE; req_prot = '0;
        ac_ready  = 1'b0; cr_valid = 1'b0; cr_resp = '0;
        cd_valid  = 1'b0; cd_data  = '0;   cd_last = 1'b0;
        dat_ready = 1'b1; rsp_ready = 1'b0;
    endtask

    // Spec-level error rule for one snoop as the driver below shapes it.
    function automatic bit model_err(input logic [4:0] cr, input int unsigned cr_after,
                                     input int unsigned last_idx, input bit stray);
        int unsigned nb;
        bit e;
        nb = cr[CR_DATA_XFER] ? BEATS : cr_after;
        e  = cr[CR_ERROR];
        for (int unsigned i = 0; i < nb; i++)
            if ((i == last_idx) != (i == BEATS - 1)) e = 1'b1;
        if (stray && (!cr[CR_DATA_XFER] || cr_after == BEATS)) e = 1'b1;
        return e;
    endfunction

    // cr_after: CD beats accepted before CR is offered; stray: an extra beat alongside CR.
    task automatic run_snoop(input ace_ac_snoop_e sn, input logic [4:0] cr,
                             input int unsigned cr_after, input int unsigned last_idx,
                             input bit stray, input int unsigned dr_mode,
                             input logic [4:0] exp_resp, input bit exp_err,
                             input int unsigned exp_beats);
        logic [AW-1:0] addr;
        logic [2:0]    prot;
        logic [DW-1:0] dbase;
        int unsigned   nb, acc, fwd, t, req_t, cr_t, last_t, done_t;
        bit            req_done, ac_seen, ac_done, cr_done, stray_done, rsp_seen, finished;
        bit            want_cr, normal;
        addr  = AW'($urandom);
        prot  = 3'($urandom_range(0, 7));
        dbase = DW'({$urandom, $urandom});
        nb    = cr[CR_DATA_XFER] ? BEATS : cr_after;
        acc = 0; fwd = 0; req_t = 0; cr_t = 0; last_t = 0;
        req_done = 0; ac_seen = 0; ac_done = 0; cr_done = 0;
        stray_done = 0; rsp_seen = 0; finished = 0;
        for (t = 0; t < 300 && !finished; t++) begin
            @(negedge aclk);
            req_valid = !req_done;
            req_addr  = addr; req_snoop = sn; req_prot = prot;
            ac_ready  = !ac_done && ($urandom_range(0, 2) != 0);
            want_cr   = ac_done && !cr_done && acc >= cr_after;
            cr_valid  = want_cr;
            cr_resp   = cr;
            normal    = ac_done && acc < nb;
            cd_valid  = normal || (stray && want_cr && !stray_done);
            cd_data   = normal ? dbase + DW'(acc) : ~dbase;
            cd_last   = normal && acc == last_idx;
            case (dr_mode)
                0:       dat_ready = 1'b1;
                1:       dat_ready = t[0];
                default: dat_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (want_cr) dat_ready = 1'b1;
            rsp_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (t == 0) chk("idle_req_ready", req_ready, 1);
            if (req_valid && req_ready) begin req_done = 1; req_t = t; end
            if (ac_valid && !ac_seen) begin
                ac_seen = 1;
                chk("ac_latency", t, req_t + 1);
                chk("ac_addr", ac_addr, addr);
                chk("ac_snoop", ac_snoop, sn);
                chk("ac_prot", ac_prot, prot);
            end
            if (ac_valid && ac_ready) ac_done = 1;
            if (cr_valid && cr_ready) begin cr_done = 1; cr_t = t; end
            if (cd_valid && cd_ready) begin
                chk("dat_valid", dat_valid, normal);
                if (normal) begin
                    chk("dat_data", dat_data, dbase + DW'(fwd));
                    chk("dat_last", dat_last, fwd == BEATS - 1);
                    fwd++; acc++;
                    if (acc == nb) last_t = t;
                end else begin
                    stray_done = 1;
                end
            end
            if (rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    done_t = (cr[CR_DATA_XFER] && last_t > cr_t) ? last_t : cr_t;
                    chk("rsp_latency", t, done_t + 1);
                    chk("rsp_resp", rsp_resp, exp_resp);
                    chk("rsp_err", rsp_err, exp_err);
                    chk("rsp_beats", fwd, exp_beats);
                    chk("busy_req_ready", req_ready, 0);
                end
                if (rsp_ready) finished = 1;
            end
        end
        if (!finished) chk("snoop_timeout", 0, 1);
        @(negedge aclk);
        idle_inputs();
    endtask

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{AC_READ_SHARED,           5'b01001, 0, 3, 0, 0, 5'b01001, 0, 4};
        tbl[1] = '{AC_READ_UNIQUE,           5'b10101, 4, 3, 0, 1, 5'b10101, 0, 4};
        tbl[2] = '{AC_READ_CLEAN,            5'b00001, 4, 2, 0, 0, 5'b00001, 1, 4};
        tbl[3] = '{AC_READ_ONCE,             5'b00000, 0, 3, 1, 0, 5'b00000, 1, 0};
        tbl[4] = '{AC_CLEAN_SHARED,          5'b00010, 0, 3, 0, 0, 5'b00010, 1, 0};
        tbl[5] = '{AC_READ_NOT_SHARED_DIRTY, 5'b01001, 2, 3, 0, 2, 5'b01001, 0, 4};
        tbl[6] = '{AC_READ_SHARED,           5'b00001, 4, 3, 1, 0, 5'b00001, 1, 4};
        tbl[7] = '{AC_MAKE_INVALID,          5'b01000, 0, 3, 0, 0, 5'b01000, 0, 0};

        idle_inputs();
        arst = 1'b1;
        repeat (3) @(negedge aclk);
        arst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_ac_valid", ac_valid, 0);
        chk("rst_cr_ready", cr_ready, 0);
        chk("rst_cd_ready", cd_ready, 0);
        chk("rst_dat_valid", dat_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ac_addr", ac_addr, 0);

        foreach (tbl[i])
            run_snoop(tbl[i].sn, tbl[i].cr, tbl[i].cr_after, tbl[i].last_idx, tbl[i].stray,
                      tbl[i].dr_mode, tbl[i].exp_resp, tbl[i].exp_err, tbl[i].exp_beats);

        // CleanInvalid with ac_ready and cr_valid high from the start: minimum latency.
        begin
            int unsigned lat;
            bit saw_dat;
            lat = 0; saw_dat = 0;
            @(negedge aclk);
            req_valid = 1'b1; req_snoop = AC_CLEAN_INVALID; req_addr = AW'(32'h1234_5678);
            ac_ready = 1'b1; cr_valid = 1'b1; cr_resp = 5'b10000;
            #1;
            chk("ci_req_ready", req_ready, 1);
            for (int n = 1; n <= 8 && lat == 0; n++) begin
                @(negedge aclk);
                req_valid = 1'b0;
                #1;
                if (dat_valid) saw_dat = 1;
                if (rsp_valid) lat = n;
            end
            chk("ci_latency", lat, 3);
            chk("ci_resp", rsp_resp, 5'b10000);
            chk("ci_err", rsp_err, 0);
            chk("ci_no_dat", saw_dat, 0);
            @(negedge aclk);
            cr_valid = 1'b0; rsp_ready = 1'b1;
            #1;
            chk("ci_rsp_held", rsp_valid, 1);
            @(negedge aclk);
            idle_inputs();
            #1;
            chk("ci_rsp_dropped", rsp_valid, 0);
            chk("ci_back_idle", req_ready, 1);
        end

        // Reset in WAIT after two beats, then a clean snoop must start from beat 0.
        begin
            @(negedge aclk);
            req_valid = 1'b1; req_snoop = AC_READ_SHARED; req_addr = AW'(32'hCAFE_0000);
            ac_ready = 1'b1;
            @(negedge aclk);
            req_valid = 1'b0;
            @(negedge aclk);
            for (int b = 0; b < 2; b++) begin
                cd_valid = 1'b1; cd_data = DW'(b); cd_last = 1'b0;
                #1;
                chk("rst_seq_dat_valid", dat_valid, 1);
                @(negedge aclk);
            end
            cd_valid = 1'b0;
            arst = 1'b1;
            @(negedge aclk);
            arst = 1'b0;
            cd_valid = 1'b1; cr_valid = 1'b1; cr_resp = 5'b00001;
            #1;
            chk("mid_rst_req_ready", req_ready, 1);
            chk("mid_rst_ac_valid", ac_valid, 0);
            chk("mid_rst_dat_valid", dat_valid, 0);
            chk("mid_rst_cr_ready", cr_ready, 0);
            chk("mid_rst_rsp_valid", rsp_valid, 0);
            chk("mid_rst_rsp_err", rsp_err, 0);
            idle_inputs();
            run_snoop(AC_READ_SHARED, 5'b01001, 1, 3, 0, 0, 5'b01001, 0, 4);
        end

        for (int k = 0; k < 40; k++) begin
            logic [4:0]  cr;
            int unsigned cr_after, last_idx, dr;
            bit          stray;
            cr       = 5'($urandom_range(0, 31));
            cr_after = $urandom_range(0, BEATS);
            last_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, BEATS) : BEATS - 1;
            stray    = ($urandom_range(0, 3) == 0);
            dr       = $urandom_range(0, 2);
            run_snoop(cr[CR_DATA_XFER] ? AC_READ_SHARED : AC_CLEAN_INVALID, cr, cr_after,
                      last_idx, stray, dr, cr, model_err(cr, cr_after, last_idx, stray),
                      cr[CR_DATA_XFER] ? BEATS : cr_after);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ace_snoop_port.md
# ace_snoop_port

Interconnect-side snoop port for one ACE master: takes a snoop request from the coherency manager, drives it onto the master's AC channel, and collects the CR response and any CD data the master's cache controller returns. Sits directly downstream of the cache controller's AC/CR/CD ports. Holds one outstanding snoop. Forwards the data beats and a summarised response back to the manager.

## Interface
- SNOOP_ADD_BUS_WIDTH, params_pkg value, AC address width
- SNOOP_DATA_BUS_WIDTH, params_pkg value, CD data width
- CD_BEATS, 4, CD beats per cache line (power of two, ≥1)
- aclk  in  1  clock; single clock domain
- arst  in  1  synchronous, active-high reset
- req_valid / req_ready  in / out  1 / 1  snoop request handshake from the coherency manager
- req_addr  in  SNOOP_ADD_BUS_WIDTH  line address
- req_snoop  in  ace_ac_snoop_e  snoop type
- req_prot  in  3  protection
- ac_valid / ac_ready  out / in  1 / 1  AC handshake to the master
- ac_addr, ac_snoop, ac_prot  out  as req  registered copy of the request
- cr_valid / cr_ready  in / out  1 / 1  CR handshake
- cr_resp  in  5  bit0 DataTransfer, bit1 Error, bit2 PassDirty, bit3 IsShared, bit4 WasUnique
- cd_valid / cd_ready  in / out  1 / 1  CD handshake
- cd_data  in  SNOOP_DATA_BUS_WIDTH  snoop data
- cd_last  in  1  last CD beat
- dat_valid / dat_ready  out / in  1 / 1  data forwarded to the manager
- dat_data  out  SNOOP_DATA_BUS_WIDTH  combinational passthrough of cd_data
- dat_last  out  1  asserted on beat CD_BEATS-1 (from the internal counter)
- rsp_valid / rsp_ready  out / in  1 / 1  completion handshake
- rsp_resp  out  5  captured cr_resp
- rsp_err  out  1  protocol or Error flag

## Operation
- FSM states: IDLE, SEND_AC, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req handshake: latch addr/snoop/prot, clear the beat counter and flags, go to SEND_AC.
- SEND_AC
  - ac_valid=1, fields held stable.
  - On ac_ready, go to WAIT.
- WAIT
  - cr_ready=1 until CR is captured, then 0.
  - CD accepted in parallel: cd_ready=dat_ready, dat_valid=cd_valid. CD may arrive before, with, or after CR.
  - Each CD handshake increments beat_cnt (width clog2(CD_BEATS)+1).
- Completion condition: CR captured, and either DataTransfer=0 or CD_BEATS beats accepted. Then go to RESP.
- RESP
  - rsp_valid=1, rsp_resp=captured CR.
  - On rsp_ready, go to IDLE.
- rsp_err is set by any of the following:
  - cr_resp[1]=1.
  - cd_last differs from (beat_cnt==CD_BEATS-1) on any accepted beat.
  - A CD beat is accepted after a CR with DataTransfer=0 has been captured.
  - In the last case, extra beats are still accepted and dropped (dat_valid=0) until the FSM leaves WAIT.
- Reset: all handshake outputs low; state IDLE; ac_*, rsp_resp, rsp_err, beat_cnt all zero. Reset mid-snoop abandons the transaction with no pending output.

## Timing
- Request accepted at cycle N gives ac_valid=1 at N+1 (registered).
- A CR or final CD handshake at cycle M gives rsp_valid=1 at M+1.
- Minimum request-to-rsp_valid latency with no data: 3 cycles (ac_ready and cr_valid high immediately).
- req_ready depends only on state. No combinational path from req_valid.
- CD→dat is a zero-latency passthrough. cd_ready may depend combinationally on dat_ready only.
- rsp_valid, ac_valid and dat_valid are never retracted before their handshake. Output fields stay stable while valid=1.
- CR and the final CD beat in the same cycle: both captured, completion evaluated on the updated values.
- beat_cnt never exceeds CD_BEATS. A beat that would overflow it counts as a protocol error and is dropped.

## Structure
- params_pkg holds:
  - CR bit index constants (CR_DATA_XFER, CR_ERROR, CR_PASS_DIRTY, CR_IS_SHARED, CR_WAS_UNIQUE).
  - ace_ac_snoop_e, SNOOP_ADD_BUS_WIDTH, SNOOP_DATA_BUS_WIDTH.
  - snoop_port_state_e.
- Single module, no sub-modules. The beat counter and flags stay inline.

## Test plan
- ReadShared, CR=5'b01001 (DataTransfer+IsShared), 4 CD beats with cd_last on beat 3, dat_ready=1 → 4 dat beats with dat_last on the 4th; rsp_resp=5'b01001, rsp_err=0.
- CleanInvalid, CR=5'b10000, no data → rsp_valid exactly 3 cycles after the req handshake (ac_ready=1 and cr_valid=1 held high from the start); no dat_valid.
- All 4 CD beats arrive before CR, with dat_ready toggling 1/0 → beats forwarded in order with backpressure honoured; rsp_valid only after CR.
- cd_last on beat 2 of 4 → rsp_err=1; the 4-beat completion rule is still enforced.
- CR=5'b00000 followed by a stray CD beat → beat dropped (dat_valid=0), rsp_err=1.
- arst pulsed in WAIT after 2 beats → next cycle all valids 0, req_ready=1; a new snoop then completes normally with beat_cnt restarting at 0.
